// File: rtl/button_debounce_repeat.sv
// Active-low push-button conditioner: per channel 2-FF synchronizer, press/release debounce
// and hold-to-repeat. Define BTN_REPEAT_EN to build the auto-repeat logic.
module button_debounce_repeat #(
  parameter int N_BTN        = 2,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000,
  parameter int CNT_W        = 25
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_held
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DB_PRESS,
    ST_HELD,
`ifdef BTN_REPEAT_EN
    ST_REPEAT,
`endif
    ST_DB_REL
  } state_t;

  localparam int MAX_AB  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;

  if (DEBOUNCE_CYC < 2 || CNT_W < $clog2(MAX_CYC)) begin : g_bad_cfg
    $error("button_debounce_repeat: CNT_W too narrow or DEBOUNCE_CYC below 2");
  end

  // The entry cycle of a debounce state already counts as the first stable sample.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 2);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn;
    logic             r_press;
    logic             r_held;
    logic             w_s;

    assign w_s = r_sync2;

    always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_btn   <= 1'b1;
        r_press <= 1'b0;
        r_held  <= 1'b0;
      end else begin
        r_sync1 <= i_btn[gi];
        r_sync2 <= r_sync1;
        r_press <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            r_btn  <= 1'b1;
            r_held <= 1'b0;
            if (!w_s) begin
              r_state <= ST_DB_PRESS;
              r_cnt   <= '0;
            end
          end
          ST_DB_PRESS: begin
            if (w_s) begin
              r_state <= ST_IDLE;
            end else if (r_cnt == DB_LAST) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
              r_btn   <= 1'b0;
              r_press <= 1'b1;
              r_held  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_HELD: begin
            r_btn <= 1'b0;
            if (w_s) begin
              r_state <= ST_DB_REL;
              r_cnt   <= '0;
            end
`ifdef BTN_REPEAT_EN
            else if (r_cnt == HOLD_LAST) begin
              r_state <= ST_REPEAT;
              r_cnt   <= '0;
              r_btn   <= 1'b1;
              r_press <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
`endif
          end
`ifdef BTN_REPEAT_EN
          ST_REPEAT: begin
            // A tick raises o_btn for one cycle; the next cycle always drops it again.
            r_btn <= 1'b0;
            if (w_s) begin
              r_state <= ST_DB_REL;
              r_cnt   <= '0;
            end else if (r_cnt == REP_LAST) begin
              r_cnt   <= '0;
              r_btn   <= 1'b1;
              r_press <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`endif
          ST_DB_REL: begin
            r_btn <= 1'b0;
            if (!w_s) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
            end else if (r_cnt == DB_LAST) begin
              r_state <= ST_IDLE;
              r_btn   <= 1'b1;
              r_held  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end

    assign o_btn[gi]   = r_btn;
    assign o_press[gi] = r_press;
    assign o_held[gi]  = r_held;
  end

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Self-checking bench for button_debounce_repeat: directed scenarios plus randomized
// per-channel pin activity, checked against a run-length/elapsed-time reference model.
module tb_button_debounce_repeat;

  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_RST = 1'b0;
  logic [1:0] i_btn = 2'b11;
  logic [1:0] o_btn;
  logic [1:0] o_press;
  logic [1:0] o_held;

  int tests = 0;
  int fails = 0;

  button_debounce_repeat #(
    .N_BTN(2), .DEBOUNCE_CYC(DB), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .CNT_W(8)
  ) dut (
    .i_CLK(clk), .i_RST(i_RST), .i_btn(i_btn),
    .o_btn(o_btn), .o_press(o_press), .o_held(o_held)
  );

  always #5 clk = ~clk;

  // Reference model: pins reach the decision logic two edges late; a level is accepted
  // after DB consecutive equal samples; ticks fall HOLD + j*REP edges after the last
  // (re)start of a continuous press.
  logic [1:0] hist[$];
  bit         pressed[2];
  int         run0[2];
  int         run1[2];
  int         anchor[2];
  int         m_cyc;
  logic [1:0] m_btn;
  logic [1:0] m_press;
  logic [1:0] m_held;

  function automatic void model_reset();
    hist = {2'b11, 2'b11};
    m_cyc = 0;
    for (int c = 0; c < 2; c++) begin
      pressed[c] = 1'b0;
      run0[c] = 0;
      run1[c] = 0;
      anchor[c] = 0;
    end
    m_btn = 2'b11;
    m_press = 2'b00;
    m_held = 2'b00;
  endfunction

  function automatic void model_edge(input logic [1:0] pins);
    logic [1:0] s;
    bit acc;
    bit tk;
    int el;
    hist.push_back(pins);
    s = hist.pop_front();
    m_cyc++;
    for (int c = 0; c < 2; c++) begin
      acc = 1'b0;
      tk = 1'b0;
      if (s[c] == 1'b0) begin
        run0[c]++;
        run1[c] = 0;
      end else begin
        run1[c]++;
        run0[c] = 0;
      end
      if (!pressed[c]) begin
        if (run0[c] == DB) begin
          acc = 1'b1;
          pressed[c] = 1'b1;
          anchor[c] = m_cyc;
        end
      end else if (s[c]) begin
        if (run1[c] == DB) pressed[c] = 1'b0;
      end else begin
        if (run0[c] == 1) anchor[c] = m_cyc;
        el = m_cyc - anchor[c];
        if (REP_EN && el >= HOLD && ((el - HOLD) % REP) == 0) tk = 1'b1;
      end
      m_press[c] = acc | tk;
      m_held[c]  = pressed[c];
      m_btn[c]   = !pressed[c] | tk;
    end
  endfunction

  // Apply one pin value for one clock edge; outputs are valid 1 time unit after the edge.
  task automatic drive(input logic [1:0] pins);
    @(negedge clk);
    i_btn = pins;
    @(posedge clk);
    model_edge(pins);
    #1;
  endtask

  task automatic test_reset();
    int t_fall;
    t_fall = -1;
    i_btn = 2'b00;
    i_RST = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o_btn, o_press, o_held} !== 6'b11_00_00) begin
      fails++;
      $display("FAIL reset_state got btn=%b press=%b held=%b want btn=11 press=00 held=00",
               o_btn, o_press, o_held);
    end
    i_RST = 1'b1;
    model_reset();
    for (int t = 1; t <= 16; t++) begin
      drive(2'b00);
      tests++;
      if ({o_btn, o_press, o_held} !== {m_btn, m_press, m_held}) begin
        fails++;
        $display("FAIL reset_model t=%0d got btn=%b press=%b held=%b want btn=%b press=%b held=%b",
                 t, o_btn, o_press, o_held, m_btn, m_press, m_held);
      end
      if (t_fall < 0 && o_btn[0] == 1'b0) t_fall = t;
    end
    tests++;
    if (t_fall != 6) begin
      fails++;
      $display("FAIL reset_fall_latency got %0d want 6", t_fall);
    end
    repeat (12) drive(2'b11);
  endtask

  task automatic test_glitch();
    int n_press;
    n_press = 0;
    for (int t = 1; t <= 14; t++) begin
      drive({1'b1, (t <= 3) ? 1'b0 : 1'b1});
      tests++;
      if ({o_btn, o_press, o_held} !== {m_btn, m_press, m_held}) begin
        fails++;
        $display("FAIL glitch_model t=%0d got btn=%b press=%b held=%b want btn=%b press=%b held=%b",
                 t, o_btn, o_press, o_held, m_btn, m_press, m_held);
      end
      if (o_press[0] || !o_btn[0]) n_press++;
    end
    tests++;
    if (n_press != 0) begin
      fails++;
      $display("FAIL glitch_no_press got %0d press/low cycles want 0", n_press);
    end
  endtask

  task automatic test_clean_press();
    int   ptimes[$];
    int   falls;
    int   t_rel;
    logic prev_btn;
    falls = 0;
    t_rel = -1;
    prev_btn = o_btn[0];
    for (int t = 1; t <= 22; t++) begin
      drive({1'b1, (t <= 10) ? 1'b0 : 1'b1});
      tests++;
      if ({o_btn, o_press, o_held} !== {m_btn, m_press, m_held}) begin
        fails++;
        $display("FAIL clean_model t=%0d got btn=%b press=%b held=%b want btn=%b press=%b held=%b",
                 t, o_btn, o_press, o_held, m_btn, m_press, m_held);
      end
      if (o_press[0]) ptimes.push_back(t);
      if (prev_btn && !o_btn[0]) falls++;
      if (t > 10 && t_rel < 0 && o_btn[0]) t_rel = t;
      prev_btn = o_btn[0];
    end
    tests++;
    if (ptimes.size() != 1 || ptimes[0] != 6) begin
      fails++;
      $display("FAIL clean_press_time got count=%0d first=%0d want count=1 first=6",
               ptimes.size(), (ptimes.size() > 0) ? ptimes[0] : -1);
    end
    tests++;
    if (falls != 1) begin
      fails++;
      $display("FAIL clean_fall_edges got %0d want 1", falls);
    end
    tests++;
    if (t_rel != 16) begin
      fails++;
      $display("FAIL clean_release_time got %0d want 16", t_rel);
    end
  endtask

  task automatic test_hold();
    int   ptimes[$];
    int   exp_t[$];
    int   falls;
    int   blip_bad;
    logic prev_btn;
    falls = 0;
    blip_bad = 0;
    prev_btn = o_btn[0];
    if (REP_EN) exp_t = {6, 26, 34, 42, 50, 58};
    else        exp_t = {6};
    for (int t = 1; t <= 72; t++) begin
      drive({1'b1, (t <= 60) ? 1'b0 : 1'b1});
      tests++;
      if ({o_btn, o_press, o_held} !== {m_btn, m_press, m_held}) begin
        fails++;
        $display("FAIL hold_model t=%0d got btn=%b press=%b held=%b want btn=%b press=%b held=%b",
                 t, o_btn, o_press, o_held, m_btn, m_press, m_held);
      end
      if (o_press[0]) begin
        ptimes.push_back(t);
        if (t > 6 && !o_btn[0]) blip_bad++;
      end
      if (prev_btn && !o_btn[0]) falls++;
      prev_btn = o_btn[0];
    end
    tests++;
    if (ptimes != exp_t) begin
      fails++;
      $display("FAIL hold_press_times got %p want %p", ptimes, exp_t);
    end
    tests++;
    if (blip_bad != 0 || falls != exp_t.size()) begin
      fails++;
      $display("FAIL hold_blips got falls=%0d missing_blips=%0d want falls=%0d missing_blips=0",
               falls, blip_bad, exp_t.size());
    end
  endtask

  task automatic test_release_bounce();
    int ptimes[$];
    int exp_t[$];
    int t_idle;
    bit lvl;
    // Short bounce right after acceptance, as on a real contact release.
    t_idle = -1;
    for (int t = 1; t <= 25; t++) begin
      lvl = (t <= 10 || t == 13) ? 1'b0 : 1'b1;
      drive({1'b1, lvl});
      tests++;
      if ({o_btn, o_press, o_held} !== {m_btn, m_press, m_held}) begin
        fails++;
        $display("FAIL bounce_model t=%0d got btn=%b press=%b held=%b want btn=%b press=%b held=%b",
                 t, o_btn, o_press, o_held, m_btn, m_press, m_held);
      end
      if (o_press[0]) ptimes.push_back(t);
      if (t > 10 && t_idle < 0 && !o_held[0]) t_idle = t;
    end
    tests++;
    if (ptimes.size() != 1 || t_idle != 19) begin
      fails++;
      $display("FAIL bounce_short got presses=%0d idle_at=%0d want presses=1 idle_at=19",
               ptimes.size(), t_idle);
    end
    // Late bounce: the hold delay must restart from the return to low.
    ptimes.delete();
    t_idle = -1;
    if (REP_EN) exp_t = {6, 43, 51};
    else        exp_t = {6};
    for (int t = 1; t <= 62; t++) begin
      lvl = (t <= 18 || (t >= 21 && t <= 50)) ? 1'b0 : 1'b1;
      drive({1'b1, lvl});
      tests++;
      if ({o_btn, o_press, o_held} !== {m_btn, m_press, m_held}) begin
        fails++;
        $display("FAIL restart_model t=%0d got btn=%b press=%b held=%b want btn=%b press=%b held=%b",
                 t, o_btn, o_press, o_held, m_btn, m_press, m_held);
      end
      if (o_press[0]) ptimes.push_back(t);
      if (t > 6 && t_idle < 0 && !o_held[0]) t_idle = t;
    end
    tests++;
    if (ptimes != exp_t || t_idle != 56) begin
      fails++;
      $display("FAIL restart_hold got presses=%p idle_at=%0d want presses=%p idle_at=56",
               ptimes, t_idle, exp_t);
    end
  endtask

  task automatic test_simultaneous();
    int n0;
    int n1;
    int skew;
    n0 = 0;
    n1 = 0;
    skew = 0;
    for (int t = 1; t <= 72; t++) begin
      drive((t <= 60) ? 2'b00 : 2'b11);
      tests++;
      if ({o_btn, o_press, o_held} !== {m_btn, m_press, m_held}) begin
        fails++;
        $display("FAIL simul_model t=%0d got btn=%b press=%b held=%b want btn=%b press=%b held=%b",
                 t, o_btn, o_press, o_held, m_btn, m_press, m_held);
      end
      if (o_press[0] !== o_press[1]) skew++;
      if (o_press[0]) n0++;
      if (o_press[1]) n1++;
    end
    tests++;
    if (skew != 0 || n0 != (REP_EN ? 6 : 1) || n1 != n0) begin
      fails++;
      $display("FAIL simul_press got ch0=%0d ch1=%0d skew=%0d want ch0=ch1=%0d skew=0",
               n0, n1, skew, REP_EN ? 6 : 1);
    end
  endtask

  task automatic test_reset_mid_press();
    int t_fall;
    t_fall = -1;
    for (int t = 1; t <= 8; t++) drive(2'b10);
    #2;
    i_RST = 1'b0;
    #1;
    tests++;
    if ({o_btn, o_press, o_held} !== 6'b11_00_00) begin
      fails++;
      $display("FAIL reset_async got btn=%b press=%b held=%b want btn=11 press=00 held=00",
               o_btn, o_press, o_held);
    end
    repeat (2) @(posedge clk);
    #1;
    i_RST = 1'b1;
    model_reset();
    for (int t = 1; t <= 12; t++) begin
      drive(2'b10);
      tests++;
      if ({o_btn, o_press, o_held} !== {m_btn, m_press, m_held}) begin
        fails++;
        $display("FAIL midrst_model t=%0d got btn=%b press=%b held=%b want btn=%b press=%b held=%b",
                 t, o_btn, o_press, o_held, m_btn, m_press, m_held);
      end
      if (t_fall < 0 && o_btn[0] == 1'b0) t_fall = t;
    end
    tests++;
    if (t_fall != 6) begin
      fails++;
      $display("FAIL midrst_redebounce got %0d want 6", t_fall);
    end
    repeat (12) drive(2'b11);
  endtask

  task automatic test_random();
    int         left[2];
    logic [1:0] lvl;
    int         r;
    int         bad;
    bad = 0;
    lvl = 2'b11;
    left[0] = 1;
    left[1] = 1;
    for (int t = 1; t <= 900; t++) begin
      for (int c = 0; c < 2; c++) begin
        left[c]--;
        if (left[c] <= 0) begin
          lvl[c] = ~lvl[c];
          r = int'($urandom_range(0, 3));
          if (r == 0)      left[c] = int'($urandom_range(1, 3));
          else if (r == 1) left[c] = int'($urandom_range(4, 8));
          else             left[c] = int'($urandom_range(10, 45));
        end
      end
      drive(lvl);
      tests++;
      if ({o_btn, o_press, o_held} !== {m_btn, m_press, m_held}) begin
        fails++;
        bad++;
        if (bad <= 20)
          $display("FAIL random_model t=%0d pins=%b got btn=%b press=%b held=%b want btn=%b press=%b held=%b",
                   t, lvl, o_btn, o_press, o_held, m_btn, m_press, m_held);
      end
    end
    repeat (12) drive(2'b11);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_clean_press();
    test_hold();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_press();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
